// File: rtl/simon_round_sequencer.sv
// Round sequencer for a single-round SimonCore: loads and expands the key, then
// runs the full round count per block (encrypt or decrypt) and returns the result over valid/ready.
module simon_round_sequencer #(
  parameter int unsigned WORD_W     = 64,
  parameter int unsigned KEY_W      = 128,
  parameter int unsigned ROUNDS_64  = 44,
  parameter int unsigned ROUNDS_128 = 68,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 smode_i,
  input  logic [KEY_W-1:0]     key_i,
  input  logic                 key_load_i,
  output logic                 key_ready_o,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 in_enc_i,
  input  logic [WORD_W-1:0]    in_x_i,
  input  logic [WORD_W-1:0]    in_y_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [WORD_W-1:0]    out_x_o,
  output logic [WORD_W-1:0]    out_y_o,
  output logic                 busy_o,
  output logic                 err_o,
  output logic                 core_kvalid_o,
  input  logic                 core_kexpdone_i,
  output logic                 core_smode_o,
  output logic [KEY_W/2-1:0]   core_keyl_o,
  output logic [KEY_W/2-1:0]   core_keyh_o,
  output logic [WORD_W-1:0]    core_data1in_o,
  output logic [WORD_W-1:0]    core_data2in_o,
  input  logic [WORD_W-1:0]    core_data1out_i,
  input  logic [WORD_W-1:0]    core_data2out_i,
  input  logic                 core_dinready_i,
  output logic                 core_dinvalid_o,
  input  logic                 core_doutvalid_i,
  output logic                 core_dencdec_o,
  output logic                 core_rsingle_o
);

  localparam int unsigned HALF_W     = WORD_W / 2;
  localparam int unsigned KHALF_W    = KEY_W / 2;
  localparam int unsigned ROUNDS_MAX = (ROUNDS_128 > ROUNDS_64) ? ROUNDS_128 : ROUNDS_64;
  localparam int unsigned CNT_W      = $clog2(ROUNDS_MAX + 1);
  localparam int unsigned TMO_W      = $clog2(TIMEOUT + 1);
  localparam logic [WORD_W-1:0] NARROW_MASK = {{(WORD_W - HALF_W){1'b0}}, {HALF_W{1'b1}}};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_KLOAD = 3'd1;
  localparam logic [2:0] S_KWAIT = 3'd2;
  localparam logic [2:0] S_READY = 3'd3;
  localparam logic [2:0] S_ISSUE = 3'd4;
  localparam logic [2:0] S_RWAIT = 3'd5;
  localparam logic [2:0] S_OUT   = 3'd6;

  if (ROUNDS_64 == 0 || ROUNDS_128 == 0) begin : g_bad_rounds
    $error("simon_round_sequencer: round counts must be at least 1");
  end
  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("simon_round_sequencer: TIMEOUT must be at least 1");
  end
  if (KEY_W != 2 * WORD_W) begin : g_bad_key
    $error("simon_round_sequencer: KEY_W must be twice WORD_W");
  end

  logic [2:0]         state_q, state_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic               smode_q, smode_d;
  logic               enc_q, enc_d;
  logic [WORD_W-1:0]  x_q, x_d;
  logic [WORD_W-1:0]  y_q, y_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [WORD_W-1:0]  out_x_q, out_x_d;
  logic [WORD_W-1:0]  out_y_q, out_y_d;
  logic               key_ready_q, key_ready_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               kvalid_q, kvalid_d;
  logic               dinvalid_q, dinvalid_d;
  logic [WORD_W-1:0]  width_mask;
  logic               tmo_hit;
  logic               waiting;

  // 64/128 mode carries only the low half of each word
  assign width_mask = smode_q ? {WORD_W{1'b1}} : NARROW_MASK;
  assign tmo_hit    = (tmo_q == TMO_W'(TIMEOUT - 1));
  assign waiting    = (state_q == S_KWAIT) || (state_q == S_ISSUE) || (state_q == S_RWAIT);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      key_q       <= '0;
      smode_q     <= 1'b0;
      enc_q       <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      key_ready_q <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      kvalid_q    <= 1'b0;
      dinvalid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      smode_q     <= smode_d;
      enc_q       <= enc_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      key_ready_q <= key_ready_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      kvalid_q    <= kvalid_d;
      dinvalid_q  <= dinvalid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    smode_d    = smode_q;
    enc_d      = enc_q;
    x_d        = x_q;
    y_d        = y_q;
    cnt_d      = cnt_q;
    out_x_d    = out_x_q;
    out_y_d    = out_y_q;
    err_d      = err_q;
    dinvalid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (key_load_i) begin
          key_d   = key_i;
          smode_d = smode_i;
          err_d   = 1'b0;
          state_d = S_KLOAD;
        end
      end
      S_KLOAD: state_d = S_KWAIT;
      S_KWAIT: begin
        if (core_kexpdone_i) begin
          state_d = S_READY;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_READY: begin
        // A key reload takes priority over a block offered in the same cycle
        if (key_load_i) begin
          key_d   = key_i;
          smode_d = smode_i;
          err_d   = 1'b0;
          state_d = S_KLOAD;
        end else if (in_valid_i) begin
          x_d     = in_x_i & width_mask;
          y_d     = in_y_i & width_mask;
          enc_d   = in_enc_i;
          cnt_d   = smode_q ? CNT_W'(ROUNDS_128) : CNT_W'(ROUNDS_64);
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (core_dinready_i) begin
          dinvalid_d = 1'b1;
          state_d    = S_RWAIT;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RWAIT: begin
        if (core_doutvalid_i) begin
          x_d   = core_data1out_i & width_mask;
          y_d   = core_data2out_i & width_mask;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            out_x_d = core_data1out_i & width_mask;
            out_y_d = core_data2out_i & width_mask;
            state_d = S_OUT;
          end else begin
            state_d = S_ISSUE;
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_OUT: begin
        if (out_ready_i) state_d = S_READY;
      end
      default: state_d = S_IDLE;
    endcase

    // Timeout counter restarts on every state entry and only runs while waiting on the core
    tmo_d = (waiting && (state_d == state_q)) ? tmo_q + TMO_W'(1) : '0;

    key_ready_d = (state_d == S_READY) || (state_d == S_ISSUE) ||
                  (state_d == S_RWAIT) || (state_d == S_OUT);
    in_ready_d  = (state_d == S_READY);
    out_valid_d = (state_d == S_OUT);
    busy_d      = (state_d != S_IDLE) && (state_d != S_READY);
    kvalid_d    = (state_d == S_KLOAD);
  end

  assign key_ready_o     = key_ready_q;
  assign in_ready_o      = in_ready_q;
  assign out_valid_o     = out_valid_q;
  assign out_x_o         = out_x_q;
  assign out_y_o         = out_y_q;
  assign busy_o          = busy_q;
  assign err_o           = err_q;
  assign core_kvalid_o   = kvalid_q;
  assign core_smode_o    = smode_q;
  assign core_keyl_o     = key_q[KHALF_W-1:0];
  assign core_keyh_o     = key_q[KEY_W-1:KHALF_W];
  assign core_data1in_o  = x_q;
  assign core_data2in_o  = y_q;
  assign core_dinvalid_o = dinvalid_q;
  assign core_dencdec_o  = enc_q;
  assign core_rsingle_o  = 1'b1;

endmodule

// File: tb/tb_simon_round_sequencer.sv
// Bench for simon_round_sequencer: behavioural single-round Simon core plus a
// scoreboard that pairs every returned block with the expected value queued at issue.
module tb_simon_round_sequencer;

  localparam logic [127:0] KEY64  = 128'h1b1a1918_13121110_0b0a0908_03020100;
  localparam logic [63:0]  P64X   = 64'h0000_0000_656b_696c;
  localparam logic [63:0]  P64Y   = 64'h0000_0000_2064_6e75;
  localparam logic [63:0]  C64X   = 64'h0000_0000_44c8_fc20;
  localparam logic [63:0]  C64Y   = 64'h0000_0000_b9df_a07a;
  localparam logic [127:0] KEY128 = 128'h0f0e0d0c0b0a0908_0706050403020100;
  localparam logic [63:0]  P128X  = 64'h6373656420737265;
  localparam logic [63:0]  P128Y  = 64'h6c6c657661727420;
  localparam logic [63:0]  C128X  = 64'h49681b1e1e54fe3f;
  localparam logic [63:0]  C128Y  = 64'h65aa832af84e0bbc;
  localparam logic [61:0]  Z2 = 62'b11001101101001111110001000010100011001001011000000111011110101;
  localparam logic [61:0]  Z3 = 62'b11110000101100111001010001001000000111101001100011010111011011;

  logic clk = 1'b0;
  logic nrst;
  logic smode_i, key_load_i, key_ready_o, in_valid_i, in_ready_o, in_enc_i;
  logic [127:0] key_i;
  logic [63:0] in_x_i, in_y_i, out_x_o, out_y_o;
  logic out_valid_o, out_ready_i, busy_o, err_o;
  logic core_kvalid_o, core_kexpdone, core_smode_o;
  logic [63:0] core_keyl_o, core_keyh_o, core_data1in_o, core_data2in_o;
  logic [63:0] core_data1out, core_data2out;
  logic core_dinready, core_dinvalid_o, core_doutvalid, core_dencdec_o, core_rsingle_o;

  int checks = 0;
  int failures = 0;
  logic [127:0] exp_q[$];
  int kv_cnt = 0;
  int din_cnt = 0;
  bit stub_dead = 1'b0;

  always #5 clk = ~clk;

  simon_round_sequencer dut (
    .clk(clk), .nrst(nrst), .smode_i(smode_i), .key_i(key_i), .key_load_i(key_load_i),
    .key_ready_o(key_ready_o), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_enc_i(in_enc_i), .in_x_i(in_x_i), .in_y_i(in_y_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_x_o(out_x_o), .out_y_o(out_y_o), .busy_o(busy_o),
    .err_o(err_o), .core_kvalid_o(core_kvalid_o), .core_kexpdone_i(core_kexpdone),
    .core_smode_o(core_smode_o), .core_keyl_o(core_keyl_o), .core_keyh_o(core_keyh_o),
    .core_data1in_o(core_data1in_o), .core_data2in_o(core_data2in_o),
    .core_data1out_i(core_data1out), .core_data2out_i(core_data2out),
    .core_dinready_i(core_dinready), .core_dinvalid_o(core_dinvalid_o),
    .core_doutvalid_i(core_doutvalid), .core_dencdec_o(core_dencdec_o),
    .core_rsingle_o(core_rsingle_o)
  );

  // ---------------- behavioural SimonCore (single-round mode) ----------------
  logic [63:0] rk [0:67];
  logic        cm_mode;
  int          cm_rounds, ridx, kexp_cnt, lat_cnt;
  logic [63:0] kk, res_x, res_y;

  function automatic logic [63:0] ror(input logic [63:0] v, input int s, input logic m);
    logic [31:0] w;
    w = v[31:0];
    if (m) return (v >> s) | (v << (64 - s));
    return {32'h0, (w >> s) | (w << (32 - s))};
  endfunction

  function automatic logic [63:0] fsim(input logic [63:0] v, input logic m);
    logic [31:0] w;
    w = v[31:0];
    if (m) return ({v[62:0], v[63]} & {v[55:0], v[63:56]}) ^ {v[61:0], v[63:62]};
    return {32'h0, ({w[30:0], w[31]} & {w[23:0], w[31:24]}) ^ {w[29:0], w[31:30]}};
  endfunction

  task automatic expand(input logic [127:0] key, input logic m);
    logic [63:0] t;
    if (!m) begin
      for (int i = 0; i < 4; i++) rk[i] = {32'h0, key[32*i +: 32]};
      for (int i = 4; i < 44; i++) begin
        t = ror(rk[i-1], 3, 1'b0) ^ rk[i-3];
        t = t ^ ror(t, 1, 1'b0);
        rk[i] = {32'h0, ~rk[i-4][31:0]} ^ t ^ 64'(Z3[i-4]) ^ 64'd3;
      end
    end else begin
      rk[0] = key[63:0];
      rk[1] = key[127:64];
      for (int i = 2; i < 68; i++) begin
        t = ror(rk[i-1], 3, 1'b1);
        t = t ^ ror(t, 1, 1'b1);
        rk[i] = ~rk[i-2] ^ t ^ 64'(Z2[(i-2) % 62]) ^ 64'd3;
      end
    end
  endtask

  always @(posedge clk) begin
    if (!nrst) begin
      core_kexpdone <= 1'b0; core_dinready <= 1'b0; core_doutvalid <= 1'b0;
      core_data1out <= '0; core_data2out <= '0;
      kexp_cnt <= 0; lat_cnt <= 0; ridx <= 0; cm_rounds <= 44; cm_mode <= 1'b0;
    end else begin
      core_kexpdone  <= 1'b0;
      core_doutvalid <= 1'b0;
      if (core_kvalid_o) begin
        expand({core_keyh_o, core_keyl_o}, core_smode_o);
        cm_mode <= core_smode_o;
        cm_rounds <= core_smode_o ? 68 : 44;
        kexp_cnt <= 4; ridx <= 0; lat_cnt <= 0; core_dinready <= 1'b0;
      end else if (kexp_cnt != 0) begin
        kexp_cnt <= kexp_cnt - 1;
        if (kexp_cnt == 1) begin core_kexpdone <= 1'b1; core_dinready <= 1'b1; end
      end else if (core_dinvalid_o && core_dinready) begin
        kk = core_dencdec_o ? rk[ridx] : rk[cm_rounds - 1 - ridx];
        if (core_dencdec_o) begin
          res_x = core_data2in_o ^ fsim(core_data1in_o, cm_mode) ^ kk;
          res_y = core_data1in_o;
        end else begin
          res_x = core_data2in_o;
          res_y = core_data1in_o ^ fsim(core_data2in_o, cm_mode) ^ kk;
        end
        ridx <= (ridx + 1 == cm_rounds) ? 0 : ridx + 1;
        core_dinready <= 1'b0;
        lat_cnt <= 3;
      end else if (lat_cnt != 0) begin
        lat_cnt <= lat_cnt - 1;
        if (lat_cnt == 1) begin
          core_dinready <= 1'b1;
          if (!stub_dead) begin
            core_doutvalid <= 1'b1;
            core_data1out  <= res_x;
            core_data2out  <= res_y;
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    if (core_kvalid_o) kv_cnt <= kv_cnt + 1;
    if (core_dinvalid_o) din_cnt <= din_cnt + 1;
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (nrst && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out: got %h expected no output", {out_x_o, out_y_o});
      end else begin
        check("out_xy", {out_x_o, out_y_o}, exp_q.pop_front());
      end
    end
  end

  task automatic load_key(input logic [127:0] k, input logic m);
    int n;
    @(negedge clk);
    key_i = k; smode_i = m; key_load_i = 1'b1;
    @(negedge clk);
    key_load_i = 1'b0;
    check("key_ready_drop", 128'(key_ready_o), 128'(0));
    n = 0;
    while (!key_ready_o && n < 200) begin @(negedge clk); n++; end
    check("key_ready_rise", 128'(key_ready_o), 128'(1));
  endtask

  task automatic send(input logic [63:0] x, input logic [63:0] y, input logic enc,
                      input logic [63:0] ex, input logic [63:0] ey, input bit expect_out);
    int n;
    n = 0;
    while (!in_ready_o && n < 3000) begin @(negedge clk); n++; end
    check("in_ready_wait", 128'(in_ready_o), 128'(1));
    if (expect_out) exp_q.push_back({ex, ey});
    in_x_i = x; in_y_i = y; in_enc_i = enc; in_valid_i = 1'b1;
    @(negedge clk);
    in_valid_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    check({tag, "_drain"}, 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    int base, kbase, n, bad;
    nrst = 1'b0;
    smode_i = 1'b0; key_i = '0; key_load_i = 1'b0; in_valid_i = 1'b0; in_enc_i = 1'b0;
    in_x_i = '0; in_y_i = '0; out_ready_i = 1'b0;

    // Reset with random inputs
    @(posedge clk);
    #1 kbase = kv_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      smode_i = 1'($urandom); key_load_i = 1'($urandom); in_valid_i = 1'($urandom);
      in_enc_i = 1'($urandom); out_ready_i = 1'($urandom);
      key_i = {$urandom, $urandom, $urandom, $urandom};
      in_x_i = {$urandom, $urandom}; in_y_i = {$urandom, $urandom};
    end
    @(negedge clk);
    check("rst_key_ready", 128'(key_ready_o), 128'(0));
    check("rst_in_ready", 128'(in_ready_o), 128'(0));
    check("rst_out_valid", 128'(out_valid_o), 128'(0));
    check("rst_busy_err", 128'({busy_o, err_o}), 128'(0));
    check("rst_out_xy", {out_x_o, out_y_o}, 128'(0));
    check("rst_core_ctl", 128'({core_dinvalid_o, core_rsingle_o}), 128'(1));
    check("rst_no_kvalid", 128'(kv_cnt - kbase), 128'(0));
    key_load_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    nrst = 1'b1;

    // 64/128 known answer, then decrypt back
    load_key(KEY64, 1'b0);
    base = din_cnt;
    send(P64X, P64Y, 1'b1, C64X, C64Y, 1'b1);
    drain("kat64");
    check("kat64_pulses", 128'(din_cnt - base), 128'(44));
    send(C64X, C64Y, 1'b0, P64X, P64Y, 1'b1);
    drain("dec64");

    // Upper halves must be ignored in 64/128 mode
    send(64'hdeadbeef_00000000 | P64X, 64'hcafef00d_00000000 | P64Y, 1'b1, C64X, C64Y, 1'b1);
    drain("upper64");

    // Output backpressure
    out_ready_i = 1'b0;
    send(P64X, P64Y, 1'b1, C64X, C64Y, 1'b1);
    n = 0;
    while (!out_valid_o && n < 3000) begin @(negedge clk); n++; end
    check("bp_valid", 128'(out_valid_o), 128'(1));
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!out_valid_o || in_ready_o || out_x_o != C64X || out_y_o != C64Y) bad++;
    end
    check("bp_hold", 128'(bad), 128'(0));
    out_ready_i = 1'b1;
    drain("bp");

    // key_load while a block is in flight is ignored
    kbase = kv_cnt;
    base = din_cnt;
    send(P64X, P64Y, 1'b1, C64X, C64Y, 1'b1);
    n = 0;
    while (din_cnt - base < 5 && n < 500) begin @(negedge clk); n++; end
    key_i = ~KEY64; key_load_i = 1'b1;
    @(negedge clk);
    key_load_i = 1'b0;
    drain("ignore_reload");
    check("ignored_kvalid", 128'(kv_cnt - kbase), 128'(0));
    load_key(KEY64, 1'b0);

    // 128/128 known answer and decrypt
    load_key(KEY128, 1'b1);
    base = din_cnt;
    send(P128X, P128Y, 1'b1, C128X, C128Y, 1'b1);
    drain("kat128");
    check("kat128_pulses", 128'(din_cnt - base), 128'(68));
    send(C128X, C128Y, 1'b0, P128X, P128Y, 1'b1);
    drain("dec128");

    // Core never answers: timeout drops the block
    load_key(KEY64, 1'b0);
    stub_dead = 1'b1;
    send(P64X, P64Y, 1'b1, '0, '0, 1'b0);
    n = 0;
    while (!err_o && n < 1500) begin @(negedge clk); n++; end
    check("tmo_err", 128'(err_o), 128'(1));
    check("tmo_latency", 128'(n >= 1024 && n < 1100), 128'(1));
    check("tmo_idle", 128'({busy_o, key_ready_o, in_ready_o, out_valid_o}), 128'(0));
    stub_dead = 1'b0;
    load_key(KEY64, 1'b0);
    check("err_cleared", 128'(err_o), 128'(0));
    send(P64X, P64Y, 1'b1, C64X, C64Y, 1'b1);
    drain("recover");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
